// File: rtl/memory.sv
// Byte-addressed RV32 data memory with registered loads, sized stores, a flash preload path and a memory-mapped output register.
// Optional feature macro: MEMORY_BOUNDS_CHECK_EN (out-of-range accesses return 0 / are dropped instead of wrapping).
module memory #(
  parameter int          WIDTH        = 32,
  parameter int          DEPTH_WORDS  = 256,
  parameter logic [31:0] OUTPORT_ADDR = 32'h0000_FFFC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] addr,
  input  logic             wren,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       funct3,
  input  logic             flash_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] outport
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    F3_BYTE   = 3'b000,
    F3_HALF   = 3'b001,
    F3_WORD   = 3'b010,
    F3_BYTE_U = 3'b100,
    F3_HALF_U = 3'b101
  } funct3_t;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [31:0]   rd_q, rd_d;
  logic [31:0]   out_q, out_d;

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          is_out;
  logic          in_range;
  logic          is_word;
  logic          mem_we;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   src;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;

  assign word_idx = addr[AW+1:2];
  assign lane     = addr[1:0];
  assign is_out   = (addr == OUTPORT_ADDR);

`ifdef MEMORY_BOUNDS_CHECK_EN
  localparam logic [WIDTH-1:0] MEM_BYTES = WIDTH'(DEPTH_WORDS * 4);
  // The output register lives above the RAM, so it is out of range here and handled separately.
  assign in_range = (addr < MEM_BYTES);
`else
  assign in_range = 1'b1;
`endif

  // Anything other than the byte/half codes is treated as a full word.
  assign is_word = !(funct3 == F3_BYTE || funct3 == F3_BYTE_U ||
                     funct3 == F3_HALF || funct3 == F3_HALF_U);

  always_comb begin
    be    = 4'b1111;
    wdata = wr_data;
    if (!flash_en) begin
      if (funct3 == F3_BYTE || funct3 == F3_BYTE_U) begin
        be    = 4'b0001 << lane;
        wdata = {4{wr_data[7:0]}};
      end else if (funct3 == F3_HALF || funct3 == F3_HALF_U) begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wr_data[15:0]}};
      end
    end
  end

  assign mem_we = flash_en ? in_range : (wren && !rst && !is_out && in_range);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    if (is_out)        src = out_q;
    else if (in_range) src = mem_q[word_idx];
    else               src = '0;
    byte_sel = src[8*lane +: 8];
    half_sel = src[16*addr[1] +: 16];
    case (funct3)
      F3_BYTE:   load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_BYTE_U: load_val = {24'h0, byte_sel};
      F3_HALF:   load_val = {{16{half_sel[15]}}, half_sel};
      F3_HALF_U: load_val = {16'h0, half_sel};
      default:   load_val = src;
    endcase
  end

  always_comb begin
    rd_d  = rd_q;
    out_d = out_q;
    if (rst) begin
      rd_d  = '0;
      out_d = '0;
    end else if (flash_en) begin
      rd_d = rd_q;
    end else if (wren) begin
      if (is_out && is_word) out_d = wr_data;
    end else begin
      rd_d = load_val;
    end
  end

  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    out_q <= out_d;
  end

  assign rd_data = rd_q;
  assign outport = out_q;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: byte-level reference model, per-cycle compare, directed literal checks, then random traffic.
module tb_memory;

  localparam logic [31:0] OUT = 32'h0000_FFFC;
  localparam int          NBYTES = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        wren;
  logic [31:0] wr_data;
  logic [2:0]  funct3;
  logic        flash_en;
  logic [31:0] rd_data;
  logic [31:0] outport;

  int errors = 0;
  int checks = 0;

  memory dut (
    .clk(clk), .rst(rst), .addr(addr), .wren(wren), .wr_data(wr_data),
    .funct3(funct3), .flash_en(flash_en), .rd_data(rd_data), .outport(outport)
  );

  always #5 clk = ~clk;

  // Reference model: plain byte array plus expected registered outputs.
  logic [7:0]  ram [NBYTES];
  logic [31:0] exp_rd = '0;
  logic [31:0] exp_out = '0;
  logic        chk_en = 1'b0;
  logic [31:0] m_nrd, m_nout, m_ba;
  int          m_n;

  function automatic int m_size(input logic [2:0] f);
    if (f == 3'b000 || f == 3'b100) return 1;
    if (f == 3'b001 || f == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit m_in(input logic [31:0] a);
`ifdef MEMORY_BOUNDS_CHECK_EN
    return a < NBYTES;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f);
    int n;
    logic [31:0] ba, v;
    n  = m_size(f);
    ba = a & ~(n - 1);
    v  = '0;
    for (int i = 0; i < n; i++) begin
      if (a == OUT)   v[8*i +: 8] = exp_out[8*i +: 8];
      else if (m_in(a)) v[8*i +: 8] = ram[(ba + i) & (NBYTES - 1)];
    end
    if (f == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (f == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  always @(posedge clk) begin
    m_nrd  = exp_rd;
    m_nout = exp_out;
    if (rst) begin
      m_nrd  = '0;
      m_nout = '0;
    end else if (!flash_en && !wren) begin
      m_nrd = m_load(addr, funct3);
    end
    if (flash_en) begin
      if (m_in(addr))
        for (int i = 0; i < 4; i++) ram[((addr & ~32'd3) + i) & (NBYTES - 1)] = wr_data[8*i +: 8];
    end else if (wren && !rst) begin
      m_n = m_size(funct3);
      if (addr == OUT) begin
        if (m_n == 4) m_nout = wr_data;
      end else if (m_in(addr)) begin
        m_ba = addr & ~(m_n - 1);
        for (int i = 0; i < m_n; i++) ram[(m_ba + i) & (NBYTES - 1)] = wr_data[8*i +: 8];
      end
    end
    exp_rd  = m_nrd;
    exp_out = m_nout;
    if (rst) chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (rd_data !== exp_rd) begin
        errors++;
        $display("FAIL model_rd_data t=%0t addr=%h got=%h exp=%h", $time, addr, rd_data, exp_rd);
      end
      checks++;
      if (outport !== exp_out) begin
        errors++;
        $display("FAIL model_outport t=%0t got=%h exp=%h", $time, outport, exp_out);
      end
    end
  end

  task automatic cyc(input logic r, input logic fl, input logic we,
                     input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    rst = r; flash_en = fl; wren = we; addr = a; wr_data = d; funct3 = f;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  logic [31:0] ra, rd;
  int          r;

  initial begin
    rst = 1'b1; flash_en = 1'b0; wren = 1'b0; addr = '0; wr_data = '0; funct3 = 3'b010;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 3'b010);
    lit("reset_rd", rd_data, 32'h0);
    lit("reset_out", outport, 32'h0);

    // Preload every word while held in reset, then the three known words.
    for (int w = 0; w < NBYTES / 4; w++) cyc(1, 1, 0, 32'(w * 4), $urandom, 3'b010);
    cyc(1, 1, 0, 0,  32'd12345,     3'b111);
    cyc(1, 1, 0, 4,  32'd678910,    3'b000);
    cyc(1, 1, 0, 14, 32'hDEADBEEF,  3'b001);
    cyc(0, 0, 0, 0,  0, 3'b010); lit("flash_rd0",  rd_data, 32'd12345);
    cyc(0, 0, 0, 4,  0, 3'b010); lit("flash_rd4",  rd_data, 32'd678910);
    cyc(0, 0, 0, 12, 0, 3'b010); lit("flash_rd12", rd_data, 32'hDEADBEEF);

    cyc(0, 0, 1, 8, 32'd101010, 3'b010);
    lit("store_holds_rd", rd_data, 32'hDEADBEEF);
    cyc(0, 0, 0, 8, 0, 3'b010); lit("store_rd8", rd_data, 32'd101010);
    cyc(0, 0, 0, 0, 0, 3'b010); lit("store_keep0", rd_data, 32'd12345);
    cyc(0, 0, 0, 4, 0, 3'b010); lit("store_keep4", rd_data, 32'd678910);

    cyc(0, 0, 0, 13, 0, 3'b000); lit("lb_13",  rd_data, 32'hFFFFFFBE);
    cyc(0, 0, 0, 13, 0, 3'b100); lit("lbu_13", rd_data, 32'h000000BE);
    cyc(0, 0, 0, 14, 0, 3'b001); lit("lh_14",  rd_data, 32'hFFFFDEAD);
    cyc(0, 0, 0, 12, 0, 3'b101); lit("lhu_12", rd_data, 32'h0000BEEF);

    cyc(0, 0, 1, 13, 32'hFFFFFF5A, 3'b000);
    cyc(0, 0, 0, 12, 0, 3'b010); lit("sb_13", rd_data, 32'hDEAD5AEF);
    cyc(0, 0, 1, 15, 32'hABCD1234, 3'b001);
    cyc(0, 0, 0, 12, 0, 3'b010); lit("sh_14", rd_data, 32'h12345AEF);

    cyc(0, 0, 1, OUT, 32'hCAFE0001, 3'b010); lit("outport_set", outport, 32'hCAFE0001);
    cyc(0, 0, 0, OUT, 0, 3'b010); lit("outport_read", rd_data, 32'hCAFE0001);
    cyc(1, 0, 0, 0, 0, 3'b010);
    lit("rst_out", outport, 32'h0);
    lit("rst_rd", rd_data, 32'h0);
    cyc(0, 0, 0, 0, 0, 3'b010); lit("rst_keeps_ram", rd_data, 32'd12345);

    cyc(1, 0, 1, 0, 32'hFFFFFFFF, 3'b010);
    cyc(0, 0, 0, 0, 0, 3'b010); lit("store_in_reset_ignored", rd_data, 32'd12345);
    cyc(0, 0, 0, NBYTES, 0, 3'b010);
`ifdef MEMORY_BOUNDS_CHECK_EN
    lit("oob_read", rd_data, 32'h0);
`else
    lit("alias_read", rd_data, 32'd12345);
`endif

    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      ra = $urandom_range(0, NBYTES - 1);
      else if (r < 92) ra = NBYTES + $urandom_range(0, NBYTES - 1);
      else             ra = OUT;
      rd = $urandom;
      r  = $urandom_range(0, 99);
      cyc(r < 3, (r >= 3 && r < 8), (r >= 8 && r < 48), ra, rd, 3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
